// File: rtl/seg_result_display.sv
// Result display stage: double-dabble BCD conversion of a signed 8-bit magnitude and a
// 4-digit multiplexed common-anode 7-segment scan. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg_result_display #(
    parameter int unsigned DIV_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       sign,
    input  logic       load,
    output logic       busy,
    output logic       signout,
    output logic [6:0] wordout,
    output logic [3:0] segout
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CONV   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;

    logic [1:0]          state_q, state_d;
    logic [7:0]          shift_q, shift_d;
    logic [11:0]         bcd_q, bcd_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                sign_pend_q, sign_pend_d;
    logic [3:0]          hund_q, hund_d;
    logic [3:0]          tens_q, tens_d;
    logic [3:0]          units_q, units_d;
    logic                signout_q, signout_d;
    logic [DIV_BITS-1:0] presc_q, presc_d;
    logic [1:0]          scan_q, scan_d;
    logic [11:0]         adj_c;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            sign_pend_q <= 1'b0;
            hund_q      <= '0;
            tens_q      <= '0;
            units_q     <= '0;
            signout_q   <= 1'b0;
            presc_q     <= '0;
            scan_q      <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            sign_pend_q <= sign_pend_d;
            hund_q      <= hund_d;
            tens_q      <= tens_d;
            units_q     <= units_d;
            signout_q   <= signout_d;
            presc_q     <= presc_d;
            scan_q      <= scan_d;
        end
    end

    // Converter FSM: one add-3/shift iteration per cycle, display regs only touched on commit
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        sign_pend_d = sign_pend_q;
        hund_d      = hund_q;
        tens_d      = tens_q;
        units_d     = units_q;
        signout_d   = signout_q;

        adj_c[3:0]  = (bcd_q[3:0]  >= 4'd5) ? bcd_q[3:0]  + 4'd3 : bcd_q[3:0];
        adj_c[7:4]  = (bcd_q[7:4]  >= 4'd5) ? bcd_q[7:4]  + 4'd3 : bcd_q[7:4];
        adj_c[11:8] = (bcd_q[11:8] >= 4'd5) ? bcd_q[11:8] + 4'd3 : bcd_q[11:8];

        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d     = value;
                    sign_pend_d = sign;
                    bcd_d       = '0;
                    cnt_d       = '0;
                    state_d     = CONV;
                end
            end
            CONV: begin
                {bcd_d, shift_d} = {adj_c, shift_q} << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                hund_d    = bcd_q[11:8];
                tens_d    = bcd_q[7:4];
                units_d   = bcd_q[3:0];
                signout_d = sign_pend_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running scan prescaler, independent of the converter
    always_comb begin
        presc_d = presc_q + DIV_BITS'(1);
        scan_d  = (&presc_q) ? scan_q + 2'd1 : scan_q;
    end

    always_comb begin
        segout  = 4'b1110;
        wordout = GLYPH_BLANK;
        case (scan_q)
            2'd0: begin
                segout  = 4'b1110;
                wordout = signout_q ? GLYPH_MINUS : GLYPH_BLANK;
            end
            2'd1: begin
                segout  = 4'b1101;
                wordout = seg7(hund_q);
`ifdef LEADING_ZERO_BLANK_EN
                if (hund_q == 4'd0) wordout = GLYPH_BLANK;
`endif
            end
            2'd2: begin
                segout  = 4'b1011;
                wordout = seg7(tens_q);
`ifdef LEADING_ZERO_BLANK_EN
                if (hund_q == 4'd0 && tens_q == 4'd0) wordout = GLYPH_BLANK;
`endif
            end
            default: begin
                segout  = 4'b0111;
                wordout = seg7(units_q);
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign signout = signout_q;

endmodule

// File: tb/tb_seg_result_display.sv
// Directed bench for seg_result_display with a short scan prescaler (DIV_BITS=2).
module tb_seg_result_display;

    localparam int unsigned DIV_BITS = 2;

    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_MINUS = 7'b0111111;
    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G7 = 7'b1111000;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] G_LZ = G_BLANK;
`else
    localparam logic [6:0] G_LZ = G0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] value;
    logic       sign;
    logic       load;
    logic       busy;
    logic       signout;
    logic [6:0] wordout;
    logic [3:0] segout;

    int n_tests = 0;
    int n_fail  = 0;

    seg_result_display #(.DIV_BITS(DIV_BITS)) dut (
        .clk(clk), .rst(rst), .value(value), .sign(sign), .load(load),
        .busy(busy), .signout(signout), .wordout(wordout), .segout(segout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_load(input logic [7:0] v, input logic s);
        @(negedge clk);
        value = v;
        sign  = s;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic count_busy(input int start, output int n);
        n = start;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Wait (bounded) for the scan to reach idx, then compare its glyph
    task automatic check_digit(input string tag, input logic [1:0] idx, input logic [6:0] exp);
        logic [3:0] want;
        int n;
        want = ~(4'b0001 << idx);
        n = 0;
        while (segout !== want && n < 64) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seg"}, 32'(segout), 32'(want));
        check(tag, 32'(wordout), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        logic [3:0] exp_seg;
        rst = 1'b1; load = 1'b0; value = '0; sign = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_segout", 32'(segout), 32'b1110);
        check("rst_wordout", 32'(wordout), 32'(G_BLANK));
        check("rst_signout", 32'(signout), 32'd0);
        rst = 1'b0;

        start_load(8'd255, 1'b0);
        count_busy(0, nb);
        check("lat255_busy_cycles", 32'(nb), 32'd9);
        check("v255_signout", 32'(signout), 32'd0);
        check_digit("v255_idx1", 2'd1, G2);
        check_digit("v255_idx2", 2'd2, G5);
        check_digit("v255_idx3", 2'd3, G5);
        check_digit("v255_idx0", 2'd0, G_BLANK);

        start_load(8'd7, 1'b1);
        count_busy(0, nb);
        check("v7_busy_cycles", 32'(nb), 32'd9);
        check("v7_signout", 32'(signout), 32'd1);
        check_digit("v7_idx0", 2'd0, G_MINUS);
        check_digit("v7_idx1", 2'd1, G_LZ);
        check_digit("v7_idx2", 2'd2, G_LZ);
        check_digit("v7_idx3", 2'd3, G7);

        start_load(8'd100, 1'b0);
        @(negedge clk);
        start_load(8'd9, 1'b1);
        count_busy(3, nb);
        check("ign_busy_cycles", 32'(nb), 32'd9);
        repeat (12) @(negedge clk);
        check("ign_busy_after", 32'(busy), 32'd0);
        check("ign_signout", 32'(signout), 32'd0);
        check_digit("ign_idx1", 2'd1, G1);
        check_digit("ign_idx2", 2'd2, G0);
        check_digit("ign_idx3", 2'd3, G0);
        check_digit("ign_idx0", 2'd0, G_BLANK);

        start_load(8'd200, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_segout", 32'(segout), 32'b1110);
        check("midrst_wordout", 32'(wordout), 32'(G_BLANK));
        check("midrst_signout", 32'(signout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 20; k++) begin
            exp_seg = ~(4'b0001 << ((k / 4) % 4));
            check($sformatf("scan_k%0d", k), 32'(segout), 32'(exp_seg));
            @(negedge clk);
        end
        check("midrst_no_commit_busy", 32'(busy), 32'd0);
        check("midrst_no_commit_sign", 32'(signout), 32'd0);
        check_digit("midrst_idx1", 2'd1, G_LZ);
        check_digit("midrst_idx2", 2'd2, G_LZ);
        check_digit("midrst_idx3", 2'd3, G0);

        start_load(8'd0, 1'b0);
        count_busy(0, nb);
        check("v0_busy_cycles", 32'(nb), 32'd9);
        check_digit("v0_idx3", 2'd3, G0);
        check_digit("v0_idx1", 2'd1, G_LZ);
        check_digit("v0_idx2", 2'd2, G_LZ);
        check_digit("v0_idx0", 2'd0, G_BLANK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
